updi_unlock_sequencer: RTL
==========================

UPDI_UNLOCK_SEQUENCER -- requirements
Module: updi_unlock_sequencer

Interface
REQ-001 SHALL have parameter MAX_INSTRUCTION_DATA_SIZE, default 64, which sets the depth of the instruction data array.
REQ-002 SHALL have parameter DATA_ADDR_BITS, default $clog2(MAX_INSTRUCTION_DATA_SIZE), which sets the data_len and rx_n_bytes width.
REQ-003 SHALL have parameter MAX_POLLS, default 255, the maximum number of ASI_SYS_STATUS reads before timeout.
REQ-004 SHALL have parameter POLL_GAP_CLK, default 1000, the idle clocks between status polls.
REQ-005 SHALL use one clock and a synchronous, active-high reset on these ports:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
REQ-006 SHALL provide these control ports:
  start  in  1  begin sequence; sampled only in IDLE
  key_sel  in  1  0 = chip-erase unlock, 1 = NVMPROG unlock; latched at start
  busy  out  1  high whenever the state is not IDLE
  done  out  1  one-cycle pulse on success
  error  out  1  held high after failure until the next start
  error_code  out  2  0 none, 1 ACK/link error, 2 key rejected, 3 poll timeout
  status_byte  out  8  last byte read by LDCS
REQ-007 SHALL provide these instruction ports, driving the UPDI interface:
  instruction  out  updi_instruction  opcode (KEY, LDCS, STCS)
  cs_addr  out  4  control/status register address
  size_c  out  2  key size; always 0 (64-bit)
  data  out  8x8  payload, element 0 sent first
  data_len  out  DATA_ADDR_BITS  payload bytes
  wait_ack_after  out  MAX_INSTRUCTION_DATA_SIZE  always 0
  tx_start / tx_ready  out / in  1  instruction transmit handshake
  rx_start / rx_ready  out / in  1  receive handshake
  rx_n_bytes  out  DATA_ADDR_BITS  always 1
  ack_error  in  1  interface reported missing/bad ACK
  out_rx_fifo_data / out_rx_fifo_rd_en / out_rx_fifo_empty  in / out / in  8/1/1  receive FIFO read port

Function
REQ-008 SHALL use these top states: IDLE, SEND_KEY, CHECK_KEY, RESET_SET, RESET_CLR, POLL, POLL_GAP, DONE, ERROR.
REQ-009 SHALL move IDLE->SEND_KEY on start=1; start SHALL be ignored in every other state.
REQ-010 In SEND_KEY, SHALL send KEY with size_c=0, data_len=8, data = "NVMErase" (key_sel=0) or "NVMProg " (key_sel=1), byte-reversed so element 0 is the last character.
REQ-011 In CHECK_KEY, SHALL issue LDCS cs_addr=0x7 and require bit 3 (key_sel=0) or bit 4 (key_sel=1) set; otherwise go to ERROR with code 2.
REQ-012 In RESET_SET, SHALL issue STCS cs_addr=0x8 with data 0x59; in RESET_CLR, STCS cs_addr=0x8 with data 0x00; data_len=1 for both.
REQ-013 In POLL, SHALL issue LDCS cs_addr=0xB; exit to DONE when bit 0 = 0 (key_sel=0) or bit 3 = 1 (key_sel=1); otherwise go to POLL_GAP, wait POLL_GAP_CLK cycles, then return to POLL.
REQ-014 SHALL count polls; if the MAX_POLLS-th read fails its exit test, go to ERROR with code 3.
REQ-015 Each access SHALL perform these steps:
  - pulse tx_start for exactly 1 cycle only while tx_ready=1, then wait for tx_ready=1 (tx_ready is low the cycle after tx_start);
  - for LDCS, pulse rx_start 1 cycle with rx_ready=1, then wait for rx_ready=1;
  - then pulse out_rx_fifo_rd_en 1 cycle when out_rx_fifo_empty=0; data is valid and captured into status_byte the following cycle.
REQ-016 Instruction fields SHALL be held stable from the tx_start cycle until the access completes.
REQ-017 ack_error=1 in any wait cycle SHALL go to ERROR with code 1 on the next edge.
REQ-018 DONE SHALL assert done for 1 cycle, then return to IDLE.
REQ-019 ERROR SHALL set error for 1 cycle, then return to IDLE with error and error_code held.
REQ-020 start in IDLE SHALL clear error and error_code.
REQ-021 tx_start, rx_start and out_rx_fifo_rd_en SHALL never be high in the same cycle.

Reset
REQ-022 rst SHALL, at the next edge and from any state including mid-access, drive state=IDLE, busy=0, done=0, error=0, error_code=0, status_byte=0x00, tx_start=0, rx_start=0, out_rx_fifo_rd_en=0, and clear all counters.

Structure
REQ-023 updi_instruction, the CS address constants (0x7, 0x8, 0xB), the two key constants, 0x59 and the error-code enum SHALL live in shared package updi_pkg.
REQ-024 The per-access handshake (REQ-015) SHALL be sub-module updi_cs_access, which has a start/done/ack_fail interface and is reused by updi_programmer.

Verification
REQ-025 Chip-erase happy path: key_sel=0, KEY_STATUS=0x08, SYS_STATUS 0x01,0x01,0x00 -> 5 instructions in order, 3 polls, done pulse, status_byte=0x00.
REQ-026 NVMPROG with key rejected: key_sel=1, KEY_STATUS=0x00 -> no STCS issued, error=1, error_code=2.
REQ-027 Poll timeout: MAX_POLLS=4, SYS_STATUS always 0x01 -> exactly 4 LDCS 0xB, error_code=3.
REQ-028 ACK fault: ack_error pulsed during RESET_SET -> error_code=1, busy falls within 2 cycles.
REQ-029 Mid-sequence reset: rst during POLL_GAP -> all outputs at reset values next cycle; a new start runs the full sequence.
REQ-030 Handshake stall: tx_ready held low 50 cycles -> tx_start stays 0 until tx_ready=1, with fields stable.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared UPDI definitions: instruction opcodes, ASI control/status addresses,
// unlock key constants and sequencer error codes.
package updi_pkg;

  typedef enum logic [1:0] {
    UPDI_LDCS = 2'd0,
    UPDI_STCS = 2'd1,
    UPDI_KEY  = 2'd2
  } updi_instruction;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ACK     = 2'd1,
    ERR_KEY     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } updi_err_t;

  localparam logic [3:0] CS_ASI_KEY_STATUS = 4'h7;
  localparam logic [3:0] CS_ASI_RESET_REQ  = 4'h8;
  localparam logic [3:0] CS_ASI_SYS_STATUS = 4'hB;

  localparam logic [7:0] RESET_SIGNATURE = 8'h59;

  // The last character lands in the low byte, so element 0 is sent first.
  localparam logic [63:0] KEY_CHIP_ERASE = "NVMErase";
  localparam logic [63:0] KEY_NVM_PROG   = "NVMProg ";

endpackage

// File: rtl/updi_cs_access.sv
// One UPDI control/status access: transmit handshake, optional receive
// handshake and a single-byte read from the receive FIFO.
module updi_cs_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_read,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       ack_error,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data,
  output logic       tx_start,
  output logic       rx_start,
  output logic       rx_fifo_rd_en,
  output logic       done,
  output logic       ack_fail,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {
    A_IDLE, A_TX_REQ, A_TX_WAIT, A_RX_REQ, A_RX_WAIT, A_FIFO_REQ, A_FIFO_RD, A_FIFO_CAP
  } acc_state_t;

  acc_state_t st;
  logic       rd_q;

  // While a start pulse is still high the interface has not yet dropped its
  // ready, so the pulse cycle itself never counts as the completion.
  assign ack_fail = ack_error && (st != A_IDLE);
  assign done     = !ack_fail &&
                    ((st == A_FIFO_CAP) ||
                     (st == A_TX_WAIT && !tx_start && tx_ready && !rd_q));
  assign rd_data  = rx_fifo_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= A_IDLE;
      rd_q          <= 1'b0;
      tx_start      <= 1'b0;
      rx_start      <= 1'b0;
      rx_fifo_rd_en <= 1'b0;
    end else if (ack_fail) begin
      st            <= A_IDLE;
      tx_start      <= 1'b0;
      rx_start      <= 1'b0;
      rx_fifo_rd_en <= 1'b0;
    end else begin
      tx_start      <= 1'b0;
      rx_start      <= 1'b0;
      rx_fifo_rd_en <= 1'b0;
      case (st)
        A_IDLE: if (start) begin
          rd_q <= is_read;
          st   <= A_TX_REQ;
        end
        A_TX_REQ: if (tx_ready) begin
          tx_start <= 1'b1;
          st       <= A_TX_WAIT;
        end
        A_TX_WAIT: if (!tx_start && tx_ready) st <= rd_q ? A_RX_REQ : A_IDLE;
        A_RX_REQ: if (rx_ready) begin
          rx_start <= 1'b1;
          st       <= A_RX_WAIT;
        end
        A_RX_WAIT: if (!rx_start && rx_ready) st <= A_FIFO_REQ;
        A_FIFO_REQ: if (!rx_fifo_empty) begin
          rx_fifo_rd_en <= 1'b1;
          st            <= A_FIFO_RD;
        end
        A_FIFO_RD:  st <= A_FIFO_CAP;
        A_FIFO_CAP: st <= A_IDLE;
        default:    st <= A_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/updi_unlock_sequencer.sv
// Drives the UPDI key / reset / status-poll sequence that unlocks a device
// for chip erase or NVM programming.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_SEND_KEY  | KEY instruction with the selected 64-bit key
// S_CHECK_KEY | LDCS ASI_KEY_STATUS, verify key accepted
// S_RESET_SET | STCS ASI_RESET_REQ = 0x59
// S_RESET_CLR | STCS ASI_RESET_REQ = 0x00
// S_POLL      | LDCS ASI_SYS_STATUS, test exit condition
// S_POLL_GAP  | idle gap between polls
// S_DONE      | one-cycle done pulse
// S_ERROR     | one-cycle failure state, error/error_code latched
module updi_unlock_sequencer
  import updi_pkg::*;
#(
  parameter int MAX_INSTRUCTION_DATA_SIZE = 64,
  parameter int DATA_ADDR_BITS            = $clog2(MAX_INSTRUCTION_DATA_SIZE),
  parameter int MAX_POLLS                 = 255,
  parameter int POLL_GAP_CLK              = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 key_sel,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [1:0]                           error_code,
  output logic [7:0]                           status_byte,
  output updi_instruction                      instruction,
  output logic [3:0]                           cs_addr,
  output logic [1:0]                           size_c,
  output logic [7:0][7:0]                      data,
  output logic [DATA_ADDR_BITS-1:0]            data_len,
  output logic [MAX_INSTRUCTION_DATA_SIZE-1:0] wait_ack_after,
  output logic                                 tx_start,
  input  logic                                 tx_ready,
  output logic                                 rx_start,
  input  logic                                 rx_ready,
  output logic [DATA_ADDR_BITS-1:0]            rx_n_bytes,
  input  logic                                 ack_error,
  input  logic [7:0]                           out_rx_fifo_data,
  output logic                                 out_rx_fifo_rd_en,
  input  logic                                 out_rx_fifo_empty
);

  localparam int POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam int GAP_W  = (POLL_GAP_CLK > 1) ? $clog2(POLL_GAP_CLK) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_KEY, S_CHECK_KEY, S_RESET_SET, S_RESET_CLR,
    S_POLL, S_POLL_GAP, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic              key_sel_q;
  logic              acc_start, acc_done, acc_fail, acc_is_read;
  logic [7:0]        acc_rd_data;
  logic [POLL_W-1:0] poll_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              key_ok, poll_exit;

  assign size_c         = 2'b00;
  assign wait_ack_after = '0;
  assign rx_n_bytes     = DATA_ADDR_BITS'(1);

  assign acc_is_read = (state == S_CHECK_KEY) || (state == S_POLL);
  assign key_ok      = key_sel_q ? acc_rd_data[4] : acc_rd_data[3];
  assign poll_exit   = key_sel_q ? acc_rd_data[3] : ~acc_rd_data[0];

  updi_cs_access u_access (
    .clk           (clk),
    .rst           (rst),
    .start         (acc_start),
    .is_read       (acc_is_read),
    .tx_ready      (tx_ready),
    .rx_ready      (rx_ready),
    .ack_error     (ack_error),
    .rx_fifo_empty (out_rx_fifo_empty),
    .rx_fifo_data  (out_rx_fifo_data),
    .tx_start      (tx_start),
    .rx_start      (rx_start),
    .rx_fifo_rd_en (out_rx_fifo_rd_en),
    .done          (acc_done),
    .ack_fail      (acc_fail),
    .rd_data       (acc_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
      status_byte <= 8'h00;
      key_sel_q   <= 1'b0;
      acc_start   <= 1'b0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      instruction <= UPDI_LDCS;
      cs_addr     <= 4'h0;
      data        <= '0;
      data_len    <= '0;
    end else begin
      acc_start <= 1'b0;
      done      <= 1'b0;
      if (acc_fail) begin
        state      <= S_ERROR;
        error      <= 1'b1;
        error_code <= ERR_ACK;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            key_sel_q  <= key_sel;
            error      <= 1'b0;
            error_code <= ERR_NONE;
            busy       <= 1'b1;
            poll_cnt   <= '0;
            acc_start  <= 1'b1;
            state      <= S_SEND_KEY;
          end
          S_SEND_KEY: if (acc_done) begin
            acc_start <= 1'b1;
            state     <= S_CHECK_KEY;
          end
          S_CHECK_KEY: if (acc_done) begin
            status_byte <= acc_rd_data;
            if (key_ok) begin
              acc_start <= 1'b1;
              state     <= S_RESET_SET;
            end else begin
              state      <= S_ERROR;
              error      <= 1'b1;
              error_code <= ERR_KEY;
            end
          end
          S_RESET_SET: if (acc_done) begin
            acc_start <= 1'b1;
            state     <= S_RESET_CLR;
          end
          S_RESET_CLR: if (acc_done) begin
            acc_start <= 1'b1;
            state     <= S_POLL;
          end
          S_POLL: if (acc_done) begin
            status_byte <= acc_rd_data;
            if (poll_exit) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else if (poll_cnt == POLL_W'(MAX_POLLS - 1)) begin
              state      <= S_ERROR;
              error      <= 1'b1;
              error_code <= ERR_TIMEOUT;
            end else begin
              poll_cnt <= poll_cnt + POLL_W'(1);
              gap_cnt  <= GAP_W'(POLL_GAP_CLK - 1);
              state    <= S_POLL_GAP;
            end
          end
          S_POLL_GAP: if (gap_cnt == '0) begin
            acc_start <= 1'b1;
            state     <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
          S_DONE, S_ERROR: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end

      // Fields follow the registered state, so they settle one cycle before
      // the access can raise tx_start and hold until the state moves on.
      case (state)
        S_SEND_KEY: begin
          instruction <= UPDI_KEY;
          cs_addr     <= 4'h0;
          data        <= key_sel_q ? KEY_NVM_PROG : KEY_CHIP_ERASE;
          data_len    <= DATA_ADDR_BITS'(8);
        end
        S_CHECK_KEY: begin
          instruction <= UPDI_LDCS;
          cs_addr     <= CS_ASI_KEY_STATUS;
          data        <= '0;
          data_len    <= '0;
        end
        S_RESET_SET: begin
          instruction <= UPDI_STCS;
          cs_addr     <= CS_ASI_RESET_REQ;
          data        <= {56'd0, RESET_SIGNATURE};
          data_len    <= DATA_ADDR_BITS'(1);
        end
        S_RESET_CLR: begin
          instruction <= UPDI_STCS;
          cs_addr     <= CS_ASI_RESET_REQ;
          data        <= '0;
          data_len    <= DATA_ADDR_BITS'(1);
        end
        S_POLL: begin
          instruction <= UPDI_LDCS;
          cs_addr     <= CS_ASI_SYS_STATUS;
          data        <= '0;
          data_len    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
